// File: rtl/ahb_bus_master_arbiter.sv
// Two-master AHB-Lite arbiter (scalar core vs. vector LSU) with split address/data-phase ownership.
// Optional scalar starvation guard compiled in with `define ARB_STARVATION_GUARD_EN.
module ahb_bus_master_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_VECT_BEATS = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_req_i,
  input  logic                  v_req_i,
  input  logic                  v_lock_i,
  input  logic [DATA_WIDTH-1:0] s_haddr_i,
  input  logic [DATA_WIDTH-1:0] s_hwdata_i,
  input  logic [DATA_WIDTH-1:0] v_haddr_i,
  input  logic [DATA_WIDTH-1:0] v_hwdata_i,
  input  logic [2:0]            s_hsize_i,
  input  logic [2:0]            v_hsize_i,
  input  logic                  s_hwrite_i,
  input  logic                  v_hwrite_i,
  output logic                  s_gnt_o,
  output logic                  v_gnt_o,
  output logic                  s_hready_o,
  output logic                  v_hready_o,
  output logic [DATA_WIDTH-1:0] s_hrdata_o,
  output logic [DATA_WIDTH-1:0] v_hrdata_o,
  output logic [1:0]            s_hresp_o,
  output logic [1:0]            v_hresp_o,
  output logic [DATA_WIDTH-1:0] haddr_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  output logic [2:0]            hsize_o,
  output logic                  hwrite_o,
  output logic [1:0]            htrans_o,
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i
);

  localparam logic [1:0] ARB_IDLE      = 2'b00;
  localparam logic [1:0] ARB_SCALAR    = 2'b01;
  localparam logic [1:0] ARB_VECTOR    = 2'b10;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0] state_reg, state_next;
  logic       dvalid_reg;
  logic       downer_reg;  // data-phase owner: 1 = vector, 0 = scalar
  logic       v_beat;
  logic       guard_trip;

  assign s_gnt_o = (state_reg == ARB_SCALAR);
  assign v_gnt_o = (state_reg == ARB_VECTOR);
  assign v_beat  = v_gnt_o & v_req_i;

`ifdef ARB_STARVATION_GUARD_EN
  localparam logic [4:0] MAX_BEATS = 5'(MAX_VECT_BEATS);
  logic [3:0] guard_cnt_reg, guard_cnt_next;
  logic [4:0] guard_inc;

  // Trip on the edge that accepts the MAX-th vector beat, so scalar gets the very next address phase.
  assign guard_inc  = {1'b0, guard_cnt_reg} + {4'd0, v_beat};
  assign guard_trip = s_req_i & (guard_inc >= MAX_BEATS);

  always_comb begin
    guard_cnt_next = guard_cnt_reg;
    if (!s_req_i || state_reg == ARB_SCALAR) begin
      guard_cnt_next = 4'd0;
    end else if (v_beat) begin
      guard_cnt_next = guard_inc[4] ? 4'hF : guard_inc[3:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      guard_cnt_reg <= 4'd0;
    end else if (hready_i) begin
      guard_cnt_reg <= guard_cnt_next;
    end
  end
`else
  assign guard_trip = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    if (hready_i) begin
      if (guard_trip && s_req_i) begin
        state_next = ARB_SCALAR;
      end else if (state_reg == ARB_VECTOR && v_lock_i) begin
        state_next = ARB_VECTOR;
      end else if (v_req_i) begin
        state_next = ARB_VECTOR;
      end else if (s_req_i) begin
        state_next = ARB_SCALAR;
      end else begin
        state_next = ARB_IDLE;
      end
    end
  end

  always_comb begin
    haddr_o  = '0;
    hsize_o  = 3'd0;
    hwrite_o = 1'b0;
    htrans_o = HTRANS_IDLE;
    case (state_reg)
      ARB_SCALAR: begin
        haddr_o  = s_haddr_i;
        hsize_o  = s_hsize_i;
        hwrite_o = s_hwrite_i;
        htrans_o = s_req_i ? HTRANS_NONSEQ : HTRANS_IDLE;
      end
      ARB_VECTOR: begin
        haddr_o  = v_haddr_i;
        hsize_o  = v_hsize_i;
        hwrite_o = v_hwrite_i;
        htrans_o = v_req_i ? HTRANS_NONSEQ : HTRANS_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg  <= ARB_IDLE;
      dvalid_reg <= 1'b0;
      downer_reg <= 1'b0;
    end else if (hready_i) begin
      state_reg  <= state_next;
      dvalid_reg <= (htrans_o == HTRANS_NONSEQ);
      downer_reg <= (state_reg == ARB_VECTOR);
    end
  end

  // Data-phase side: the old owner finishes through downer while the new owner drives the address.
  assign hwdata_o   = !dvalid_reg ? '0 : (downer_reg ? v_hwdata_i : s_hwdata_i);
  assign s_hready_o = hready_i & ~reset_i & ((dvalid_reg & ~downer_reg) | s_gnt_o);
  assign v_hready_o = hready_i & ~reset_i & ((dvalid_reg & downer_reg) | v_gnt_o);
  assign s_hresp_o  = (dvalid_reg & ~downer_reg) ? hresp_i : 2'b00;
  assign v_hresp_o  = (dvalid_reg & downer_reg) ? hresp_i : 2'b00;
  assign s_hrdata_o = hrdata_i;
  assign v_hrdata_o = hrdata_i;

endmodule
